roulette_ctrl: RTL and testbench
================================

Name: roulette_ctrl

Overview:
- Sequencer for the 4-position LED roulette on the DE-class board.
- Turns a start pulse and a stop request into a timed spin, a deceleration phase and a result hold.
- Drives the one-hot LED position and a 7-segment digit for the result.
- Sits between the debounced switch inputs and the LEDR/HEX0 pins in top.

Parameters:
PW, 32, width of the period counter and period register.
BASE_PERIOD, 2500000, CLOCK_50 cycles per step while spinning (minimum 2).
PERIOD_INC, 1250000, cycles added to the period after each deceleration step.
DECEL_STEPS, 8, number of steps taken in DECEL before stopping (minimum 1).
HOLD_CYCLES, 50000000, cycles the result is shown in SHOW before returning to IDLE (minimum 1).

Ports:
CLOCK_50  in   1  system clock; all logic is on its rising edge.
rst       in   1  synchronous, active-high reset.
start     in   1  level input; its rising edge begins a spin.
stop_req  in   1  level input; its rising edge begins deceleration.
led       out  4  one-hot current position; bit n is lit for position n.
hex       out  7  active-low segments (bit6=g … bit0=a) showing the current position digit 0-3.
busy      out  1  high in SPIN and DECEL.
result_valid out 1  high in SHOW, and in IDLE once any spin has completed.
done      out  1  one-cycle pulse on the cycle SHOW is entered.

Behaviour:
- Single clock, CLOCK_50. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, pos=0, led=4'b0001, hex=7'b1000000.
  - busy=0, result_valid=0, done=0, cnt=0, period=BASE_PERIOD, dstep=0.
  - start_q=1 and stop_q=1, so a level held through reset does not fire.
- Edge detection, registered: rise_start = start & ~start_q; rise_stop = stop_req & ~stop_q.
- step = (cnt == period-1).
  - On step: cnt←0 and pos←pos+1 modulo 4 (3 wraps to 0).
  - Otherwise cnt←cnt+1.
  - cnt only runs in SPIN and DECEL.
- Hex encoding for pos: 0=1000000, 1=1111001, 2=0100100, 3=0110000.
- led and hex are pure decodes of registered pos. They update on the edge after step.
- IDLE:
  - Outputs hold the last pos.
  - rise_start → SPIN, with cnt←0, period←BASE_PERIOD, result_valid←0.
  - rise_stop is ignored.
- SPIN:
  - Steps every BASE_PERIOD cycles.
  - rise_stop → DECEL, with cnt←0, period←BASE_PERIOD+PERIOD_INC, dstep←0. The partial period is discarded and no step occurs on that cycle.
  - If step and rise_stop coincide, pos advances and DECEL is still entered.
  - rise_start is ignored.
- DECEL:
  - On each step: dstep←dstep+1 and period←period+PERIOD_INC, saturating at 2^PW-1.
  - On the step where dstep==DECEL_STEPS-1: pos advances, then go to SHOW with done=1 for one cycle, result_valid←1, cnt←0.
  - rise_start and rise_stop are ignored.
- SHOW:
  - pos is frozen.
  - cnt counts HOLD_CYCLES, then → IDLE with result_valid kept at 1.
  - rise_start is ignored.
- Simultaneous edges: in IDLE with rise_start and rise_stop on the same cycle, start wins and the stop edge is consumed, so no DECEL follows.
- Reset mid-operation (any state) returns all registers to reset values on the next edge. A pending edge is lost.
- Deceleration step k (k=1..DECEL_STEPS) lasts BASE_PERIOD + k·PERIOD_INC cycles.
- Total stop-edge to done latency = DECEL_STEPS·BASE_PERIOD + PERIOD_INC·DECEL_STEPS·(DECEL_STEPS+1)/2 cycles.

Test Plan:
(Bench parameters: BASE_PERIOD=4, PERIOD_INC=2, DECEL_STEPS=3, HOLD_CYCLES=5.)
- Reset: assert rst for 2 cycles with start=1 held → led=0001, hex=1000000, busy=0, result_valid=0. No spin starts after release while start stays 1.
- Spin timing: 1-cycle start pulse → busy=1. led goes 0010, 0100, 1000, 0001 at exactly 4-cycle intervals (wrap 3→0 checked).
- Decel and result:
  - Raise stop_req on the cycle after the step to pos=2 → steps after 6, 8, 10 cycles give pos 3, 0, 1.
  - done pulses once with pos=1, hex=1111001, result_valid=1, busy=0.
  - After 5 more cycles state is IDLE with result_valid still 1.
- Ignored inputs:
  - stop_req edges in IDLE, DECEL and SHOW change nothing.
  - start edges in SPIN, DECEL and SHOW change nothing.
  - Decel step intervals remain 6/8/10.
- Simultaneous edges: start and stop_req rise on the same IDLE cycle → SPIN entered and stays spinning (no DECEL) for ≥20 cycles.
- Mid-operation reset: rst during DECEL → next cycle led=0001, busy=0, done never pulses. A new start runs a full normal spin.

Source files
------------

// File: rtl/roulette_ctrl_if.sv
// Switch-side inputs and LED/HEX-side outputs of the roulette sequencer.
// The slave modport belongs to the sequencer; the master drives start/stop_req.
interface roulette_ctrl_if;
  logic       start;
  logic       stop_req;
  logic [3:0] led;
  logic [6:0] hex;
  logic       busy;
  logic       result_valid;
  logic       done;

  modport master (
    output start, stop_req,
    input  led, hex, busy, result_valid, done
  );

  modport slave (
    input  start, stop_req,
    output led, hex, busy, result_valid, done
  );
endinterface

// File: rtl/roulette_ctrl.sv
// 4-position LED roulette sequencer: spin at a fixed period, decelerate
// with a growing period after a stop request, then hold the result.
module roulette_ctrl #(
  parameter int unsigned PW          = 32,
  parameter int unsigned BASE_PERIOD = 2500000,
  parameter int unsigned PERIOD_INC  = 1250000,
  parameter int unsigned DECEL_STEPS = 8,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  roulette_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SPIN, DECEL, SHOW} state_e;

  localparam int unsigned   DW         = (DECEL_STEPS > 1) ? $clog2(DECEL_STEPS) : 1;
  localparam logic [PW-1:0] BASE_P     = PW'(BASE_PERIOD);
  localparam logic [PW-1:0] INC_P      = PW'(PERIOD_INC);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DSTEP_LAST = DW'(DECEL_STEPS - 1);

  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[PW] ? '1 : sum[PW-1:0];
  endfunction

  function automatic logic [6:0] hex_enc(input logic [1:0] p);
    case (p)
      2'd0:    return 7'b1000000;
      2'd1:    return 7'b1111001;
      2'd2:    return 7'b0100100;
      default: return 7'b0110000;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    pos_q, pos_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic [DW-1:0] dstep_q, dstep_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          result_valid_q, result_valid_d;
  logic          done_q, done_d;

  logic rise_start, rise_stop, step;

  assign rise_start = bus.start & ~start_q;
  assign rise_stop  = bus.stop_req & ~stop_q;
  assign step       = (cnt_q == period_q - PW'(1));

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    dstep_d        = dstep_q;
    start_d        = bus.start;
    stop_d         = bus.stop_req;
    result_valid_d = result_valid_q;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_start) begin
          state_d        = SPIN;
          cnt_d          = '0;
          period_d       = BASE_P;
          result_valid_d = 1'b0;
        end
      end
      SPIN: begin
        if (step) begin
          pos_d = pos_q + 2'd1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
        // The partial period is dropped: deceleration restarts the count.
        if (rise_stop) begin
          state_d  = DECEL;
          cnt_d    = '0;
          period_d = sat_add(BASE_P, INC_P);
          dstep_d  = '0;
        end
      end
      DECEL: begin
        if (step) begin
          pos_d    = pos_q + 2'd1;
          cnt_d    = '0;
          dstep_d  = dstep_q + DW'(1);
          period_d = sat_add(period_q, INC_P);
          if (dstep_q == DSTEP_LAST) begin
            state_d        = SHOW;
            done_d         = 1'b1;
            result_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      SHOW: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge-detect history resets high so a level held through reset never fires.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q        <= IDLE;
      pos_q          <= 2'd0;
      cnt_q          <= '0;
      period_q       <= BASE_P;
      dstep_q        <= '0;
      start_q        <= 1'b1;
      stop_q         <= 1'b1;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      dstep_q        <= dstep_d;
      start_q        <= start_d;
      stop_q         <= stop_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  assign bus.led          = 4'b0001 << pos_q;
  assign bus.hex          = hex_enc(pos_q);
  assign bus.busy         = (state_q == SPIN) || (state_q == DECEL);
  assign bus.result_valid = result_valid_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_roulette_ctrl.sv
// Bench for roulette_ctrl: runs are planned with plain timing arithmetic, expected
// LED-step/done events are queued, and a monitor compares every cycle.
module tb_roulette_ctrl;

  localparam int BP   = 4;
  localparam int PI   = 2;
  localparam int DS   = 3;
  localparam int HC   = 5;
  localparam int MAXC = 2048;
  localparam logic [6:0] HEX_TAB [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};

  typedef struct {
    int cyc;
    int pos;
    bit dn;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_pos = 0;

  bit   sched_rst   [MAXC];
  bit   sched_start [MAXC];
  bit   sched_stop  [MAXC];
  bit   exp_busy    [MAXC];
  bit   exp_rv      [MAXC];
  ev_t  evq [$];

  roulette_ctrl_if bif ();

  roulette_ctrl #(
    .PW          (32),
    .BASE_PERIOD (BP),
    .PERIOD_INC  (PI),
    .DECEL_STEPS (DS),
    .HOLD_CYCLES (HC)
  ) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .bus      (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Inputs for edge e are applied just after edge e-1.
  initial begin
    rst          = 1'b1;
    bif.start    = 1'b1;
    bif.stop_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc + 1 < MAXC) begin
        rst          = sched_rst[cyc+1];
        bif.start    = sched_start[cyc+1];
        bif.stop_req = sched_stop[cyc+1];
      end
    end
  end

  // Monitor: an output event is a change of the LED position or a done pulse.
  initial begin
    logic [3:0] prev_led;
    logic [3:0] exp_led;
    bit         ev;
    ev_t        e;
    int         cur_pos;
    prev_led = 4'b0001;
    cur_pos  = 0;
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        ev = (bif.led !== prev_led) || (bif.done === 1'b1);
        if (ev) begin
          if (evq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event at cycle %0d: led=%b done=%b, expected no event",
                     cyc, bif.led, bif.done);
          end else begin
            e = evq.pop_front();
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            chk("event_done", 32'(bif.done), 32'(e.dn));
            cur_pos = e.pos;
          end
        end
        exp_led = 4'b0001 << cur_pos;
        chk("led", 32'(bif.led), 32'(exp_led));
        chk("hex", 32'(bif.hex), 32'(HEX_TAB[cur_pos]));
        chk("busy", 32'(bif.busy), 32'(exp_busy[cyc]));
        chk("result_valid", 32'(bif.result_valid), 32'(exp_rv[cyc]));
        prev_led = bif.led;
      end
    end
  end

  task automatic set_range(input int a, input bit b, input bit rv);
    for (int i = a; i < MAXC; i++) begin
      exp_busy[i] = b;
      exp_rv[i]   = rv;
    end
  endtask

  // One start/stop run beginning at edge s with the stop edge n cycles later.
  // Step k of the deceleration lasts BP + k*PI cycles; the last one raises done.
  task automatic plan_run(input int s, input int n, input bit inj, input bit simul,
                          input int rst_off, output int nxt);
    int p, t, r, done_t;
    while (cyc < s - 6) @(negedge clk);
    p = s + n;
    r = (rst_off >= 0) ? p + rst_off : MAXC;
    sched_start[s] = 1'b1;
    sched_stop[p]  = 1'b1;
    if (simul) sched_stop[s] = 1'b1;
    if (inj) begin
      sched_stop[s-3] = 1'b1;
      if (n >= 4) sched_start[s+2] = 1'b1;
    end
    set_range(s, 1'b1, 1'b0);
    for (int k = 1; BP * k <= n; k++) begin
      m_pos = (m_pos + 1) % 4;
      evq.push_back(ev_t'{s + BP * k, m_pos, 1'b0});
    end
    t = p;
    for (int k = 1; k <= DS; k++) begin
      t = t + BP + k * PI;
      if (t >= r) break;
      m_pos = (m_pos + 1) % 4;
      evq.push_back(ev_t'{t, m_pos, (k == DS)});
    end
    if (rst_off >= 0) begin
      sched_rst[r] = 1'b1;
      if (m_pos != 0) evq.push_back(ev_t'{r, 0, 1'b0});
      m_pos = 0;
      set_range(r, 1'b0, 1'b0);
      nxt = r + 4 + int'($urandom_range(0, 4));
    end else begin
      done_t = t;
      set_range(done_t, 1'b0, 1'b1);
      if (inj) begin
        sched_start[p+3]      = 1'b1;
        sched_stop[p+10]      = 1'b1;
        sched_start[p+12]     = 1'b1;
        sched_start[done_t+2] = 1'b1;
        sched_stop[done_t+3]  = 1'b1;
        sched_start[done_t+4] = 1'b1;
      end
      nxt = done_t + HC + 3 + int'($urandom_range(0, 6));
    end
  endtask

  initial begin
    int s;
    sched_rst[1] = 1'b1;
    sched_rst[2] = 1'b1;
    for (int i = 1; i <= 12; i++) sched_start[i] = 1'b1;
    s = 20;
    plan_run(s, 9, 1'b1, 1'b0, -1, s);
    plan_run(s, 17, 1'b1, 1'b0, -1, s);
    plan_run(s, 16, 1'b0, 1'b0, -1, s);
    plan_run(s, 22, 1'b0, 1'b1, -1, s);
    plan_run(s, 5, 1'b0, 1'b0, 8, s);
    plan_run(s, 12, 1'b1, 1'b0, -1, s);
    repeat (10) begin
      plan_run(s, int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)), 1'b0, -1, s);
    end
    while (cyc < s + 5) @(negedge clk);
    chk("pending_events", 32'(evq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL timeout at cycle %0d: simulation did not complete, expected finish before cycle %0d",
             cyc, MAXC);
    $fatal(1, "timeout");
  end

endmodule
